// File: rtl/wrapping_increment_counter_pkg.sv
// Shared helpers for the wrapping increment counter.
// Also provides the CLOG2 width macro when no common header has already defined it.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package wrapping_increment_counter_pkg;

  // True when value is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/wrapping_increment_counter.sv
// Modulo-RANGE counter with clear/load/increment requests and a one-cycle wrap pulse.
// Priority: clear > load > increment. Power-of-two ranges wrap on the adder carry;
// other ranges compare the widened sum against RANGE and subtract once.
module wrapping_increment_counter
  import wrapping_increment_counter_pkg::*;
#(
  parameter int unsigned RANGE       = 4,
  parameter int unsigned RANGE_LOG2  = `CLOG2(RANGE),
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [RANGE_LOG2-1:0] load_value,
  input  logic                  increment,
  input  logic [RANGE_LOG2-1:0] increment_amount,
  output logic [RANGE_LOG2-1:0] count,
  output logic                  count_is_max,
  output logic                  wrapped
);

  localparam bit                    RANGE_IS_POW2 = is_pow2(RANGE);
  localparam logic [RANGE_LOG2-1:0] COUNTER_MAX   = RANGE_LOG2'(RANGE - 1);
  localparam logic [RANGE_LOG2-1:0] RESET_COUNT   = RANGE_LOG2'(RESET_VALUE);

  logic [RANGE_LOG2-1:0] count_q, count_d;
  logic                  wrapped_q, wrapped_d;

  // Datapath results consumed by the next-state logic
  logic [RANGE_LOG2-1:0] inc_next;
  logic                  inc_wrap;
  logic [RANGE_LOG2-1:0] load_sel;

  // Widened sum so the carry out of the count width is visible
  logic [RANGE_LOG2:0]   inc_sum;
  assign inc_sum = {1'b0, count_q} + {1'b0, increment_amount};

  if (RANGE_IS_POW2) begin : g_pow2
    // Every load_value is in range and the carry is exactly the wrap condition
    assign inc_next = inc_sum[RANGE_LOG2-1:0];
    assign inc_wrap = inc_sum[RANGE_LOG2];
    assign load_sel = load_value;
  end else begin : g_non_pow2
    localparam logic [RANGE_LOG2:0] RANGE_EXT = (RANGE_LOG2 + 1)'(RANGE);

    logic [RANGE_LOG2:0] inc_diff;
    assign inc_diff = inc_sum - RANGE_EXT;
    assign inc_wrap = (inc_sum >= RANGE_EXT);
    // A single subtraction; an illegal step may still leave the count out of range
    assign inc_next = inc_wrap ? inc_diff[RANGE_LOG2-1:0] : inc_sum[RANGE_LOG2-1:0];
    // Out-of-range loads saturate to the top count
    assign load_sel = (load_value > COUNTER_MAX) ? COUNTER_MAX : load_value;

    // Flag illegal requests that actually take effect this cycle
    always @(posedge clock) begin
      if (!reset && !clear && load) begin
        assert (load_value <= COUNTER_MAX)
          else $warning("wrapping_increment_counter: load_value %0d out of range", load_value);
      end
      if (!reset && !clear && !load && increment) begin
        assert (increment_amount <= COUNTER_MAX)
          else $warning("wrapping_increment_counter: increment_amount %0d out of range",
                        increment_amount);
      end
    end
  end

  // Next-state selection by request priority; wrap pulses only for a winning increment
  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
    if (clear) begin
      count_d = RESET_COUNT;
    end else if (load) begin
      count_d = load_sel;
    end else if (increment) begin
      count_d   = inc_next;
      wrapped_d = inc_wrap;
    end
  end

  // Count and wrap-pulse registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q   <= RESET_COUNT;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count        = count_q;
  assign wrapped      = wrapped_q;
  assign count_is_max = (count_q == COUNTER_MAX);

endmodule

// File: tb/tb_wrapping_increment_counter.sv
// Self-checking bench: directed vector table, random stimulus against an arithmetic
// model, and hand-written reset sequences. Three instances cover RANGE 5, 8 and 4.
module tb_wrapping_increment_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // RANGE=5, RESET_VALUE=0
  logic       clr5 = 1'b0, ld5 = 1'b0, inc5 = 1'b0;
  logic [2:0] lv5 = '0, amt5 = '0;
  logic [2:0] cnt5;
  logic       max5, wr5;
  // RANGE=8, RESET_VALUE=2
  logic       clr8 = 1'b0, ld8 = 1'b0, inc8 = 1'b0;
  logic [2:0] lv8 = '0, amt8 = '0;
  logic [2:0] cnt8;
  logic       max8, wr8;
  // RANGE=4, RESET_VALUE=3 (only reset behaviour is checked)
  logic [1:0] cnt4;
  logic       max4, wr4;

  wrapping_increment_counter #(.RANGE(5), .RESET_VALUE(0)) u_dut5 (
    .clock(clk), .reset(rst), .clear(clr5), .load(ld5), .load_value(lv5),
    .increment(inc5), .increment_amount(amt5), .count(cnt5), .count_is_max(max5),
    .wrapped(wr5)
  );

  wrapping_increment_counter #(.RANGE(8), .RESET_VALUE(2)) u_dut8 (
    .clock(clk), .reset(rst), .clear(clr8), .load(ld8), .load_value(lv8),
    .increment(inc8), .increment_amount(amt8), .count(cnt8), .count_is_max(max8),
    .wrapped(wr8)
  );

  wrapping_increment_counter #(.RANGE(4), .RESET_VALUE(3)) u_dut4 (
    .clock(clk), .reset(rst), .clear(clr8), .load(ld8), .load_value(lv8[1:0]),
    .increment(inc8), .increment_amount(amt8[1:0]), .count(cnt4), .count_is_max(max4),
    .wrapped(wr4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: current count and wrap output for each checked instance
  int m5c = 0, m8c = 2;
  bit m5w = 1'b0, m8w = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Counter behaviour stated as modular arithmetic
  function automatic void model(input int range, input int rv, input int cur, input bit clr,
                                input bit ld, input int lv, input bit inc, input int amt,
                                output int nxt, output bit wr);
    nxt = cur;
    wr  = 1'b0;
    if (clr) nxt = rv;
    else if (ld) nxt = (lv < range) ? lv : range - 1;
    else if (inc) begin
      wr  = (cur + amt) >= range;
      nxt = (cur + amt) % range;
    end
  endfunction

  // Advance one clock; models follow the inputs presented at the edge
  task automatic tick();
    int n5c, n8c;
    bit n5w, n8w;
    model(5, 0, m5c, clr5, ld5, int'(lv5), inc5, int'(amt5), n5c, n5w);
    model(8, 2, m8c, clr8, ld8, int'(lv8), inc8, int'(amt8), n8c, n8w);
    @(posedge clk);
    #1;
    if (rst) begin
      m5c = 0; m5w = 1'b0; m8c = 2; m8w = 1'b0;
    end else begin
      m5c = n5c; m5w = n5w; m8c = n8c; m8w = n8w;
    end
  endtask

  task automatic idle_all();
    {clr5, ld5, inc5} = 3'b000; lv5 = '0; amt5 = '0;
    {clr8, ld8, inc8} = 3'b000; lv8 = '0; amt8 = '0;
  endtask

  typedef struct {
    int    which;  // 0 drives the RANGE=5 instance, 1 the RANGE=8 instance
    bit    clr;
    bit    ld;
    int    lv;
    bit    inc;
    int    amt;
    int    cnt;
    bit    wr;
    bit    mx;
    string note;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;

    // RANGE=5 from count 0
    tbl.push_back('{0, 0, 0, 0, 1, 1, 1, 0, 0, "r5_inc_a"});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 2, 0, 0, "r5_inc_b"});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 3, 0, 0, "r5_inc_c"});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 4, 0, 1, "r5_inc_d"});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 0, 1, 0, "r5_inc_wrap"});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 1, 0, 0, "r5_inc_e"});
    tbl.push_back('{0, 0, 0, 0, 1, 1, 2, 0, 0, "r5_inc_f"});
    tbl.push_back('{0, 0, 1, 3, 0, 0, 3, 0, 0, "r5_load3"});
    tbl.push_back('{0, 0, 0, 0, 1, 4, 2, 1, 0, "r5_3_plus_4"});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 2, 0, 0, "r5_hold"});
    tbl.push_back('{0, 0, 1, 6, 0, 0, 4, 0, 1, "r5_load_illegal"});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 4, 0, 1, "r5_inc_zero"});
    tbl.push_back('{0, 0, 1, 1, 1, 1, 1, 0, 0, "r5_load_beats_wrap"});
    tbl.push_back('{0, 0, 1, 4, 0, 0, 4, 0, 1, "r5_load4"});
    tbl.push_back('{0, 1, 1, 3, 1, 1, 0, 0, 0, "r5_clear_beats_all"});
    // RANGE=8, RESET_VALUE=2, still at reset count
    tbl.push_back('{1, 0, 1, 6, 0, 0, 6, 0, 0, "r8_load6"});
    tbl.push_back('{1, 0, 0, 0, 1, 3, 1, 1, 0, "r8_6_plus_3"});
    tbl.push_back('{1, 0, 1, 7, 0, 0, 7, 0, 1, "r8_load7_max"});
    tbl.push_back('{1, 0, 0, 0, 1, 1, 0, 1, 0, "r8_carry_wrap"});
    tbl.push_back('{1, 1, 1, 5, 1, 1, 2, 0, 0, "r8_clear_beats_all"});
    tbl.push_back('{1, 0, 1, 4, 1, 3, 4, 0, 0, "r8_load_beats_inc"});
    tbl.push_back('{1, 0, 0, 0, 1, 7, 3, 1, 0, "r8_4_plus_7"});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 3, 0, 0, "r8_inc_zero"});

    // Asynchronous reset with no clock edge yet
    #1 rst = 1'b1;
    #1;
    check("rst_async_cnt5", int'(cnt5), 0);
    check("rst_async_wr5", int'(wr5), 0);
    check("rst_async_max5", int'(max5), 0);
    check("rst_async_cnt8", int'(cnt8), 2);
    check("rst_async_max8", int'(max8), 0);
    check("rst_async_cnt4", int'(cnt4), 3);
    check("rst_async_max4", int'(max4), 1);

    // Requests during reset are discarded
    inc5 = 1'b1; amt5 = 3'd1; inc8 = 1'b1; amt8 = 3'd1;
    tick();
    check("rst_hold_cnt5", int'(cnt5), 0);
    check("rst_hold_cnt8", int'(cnt8), 2);
    idle_all();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      idle_all();
      if (v.which == 0) begin
        clr5 = v.clr; ld5 = v.ld; lv5 = 3'(v.lv); inc5 = v.inc; amt5 = 3'(v.amt);
      end else begin
        clr8 = v.clr; ld8 = v.ld; lv8 = 3'(v.lv); inc8 = v.inc; amt8 = 3'(v.amt);
      end
      tick();
      if (v.which == 0) begin
        check({v.note, "_cnt"}, int'(cnt5), v.cnt);
        check({v.note, "_wr"}, int'(wr5), int'(v.wr));
        check({v.note, "_max"}, int'(max5), int'(v.mx));
      end else begin
        check({v.note, "_cnt"}, int'(cnt8), v.cnt);
        check({v.note, "_wr"}, int'(wr8), int'(v.wr));
        check({v.note, "_max"}, int'(max8), int'(v.mx));
      end
    end

    // Random legal traffic on both instances against the model
    for (int i = 0; i < 400; i++) begin
      clr5 = ($urandom_range(15) == 0);
      ld5  = ($urandom_range(7) == 0);
      lv5  = 3'($urandom_range(4));
      inc5 = ($urandom_range(3) != 0);
      amt5 = 3'($urandom_range(4));
      clr8 = ($urandom_range(15) == 0);
      ld8  = ($urandom_range(7) == 0);
      lv8  = 3'($urandom_range(7));
      inc8 = ($urandom_range(3) != 0);
      amt8 = 3'($urandom_range(7));
      tick();
      check("rand_cnt5", int'(cnt5), m5c);
      check("rand_wr5", int'(wr5), int'(m5w));
      check("rand_max5", int'(max5), int'(m5c == 4));
      check("rand_cnt8", int'(cnt8), m8c);
      check("rand_wr8", int'(wr8), int'(m8w));
      check("rand_max8", int'(max8), int'(m8c == 7));
    end

    // Reset mid-cycle while a wrap pulse is showing
    idle_all();
    ld5 = 1'b1; lv5 = 3'd4;
    tick();
    idle_all();
    inc5 = 1'b1; amt5 = 3'd1;
    tick();
    check("pre_rst_wr5", int'(wr5), 1);
    check("pre_rst_cnt5", int'(cnt5), 0);
    inc8 = 1'b1; amt8 = 3'd1;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cnt5", int'(cnt5), 0);
    check("mid_rst_wr5", int'(wr5), 0);
    check("mid_rst_cnt8", int'(cnt8), 2);
    check("mid_rst_wr8", int'(wr8), 0);
    check("mid_rst_cnt4", int'(cnt4), 3);
    check("mid_rst_max4", int'(max4), 1);
    tick();
    check("rst_edge_cnt5", int'(cnt5), 0);
    check("rst_edge_cnt8", int'(cnt8), 2);
    rst = 1'b0;
    tick();
    check("post_rst_cnt5", int'(cnt5), 1);
    check("post_rst_cnt8", int'(cnt8), 3);
    check("post_rst_model5", int'(cnt5), m5c);
    idle_all();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
